link_sprite_ctrl: RTL and testbench
===================================

# link_sprite_ctrl

Sequencer for Link's 32x32 sprite ROMs in the VGA pixel path. Per frame it latches Link's position, facing direction and walk state. It runs the walk-animation state machine and selects which direction ROM is read. Per pixel it generates the ROM address for the current DrawX/DrawY and outputs a palette index plus an opacity flag, pipeline-aligned, to the colour mapper.

## Interface
Parameters:
- ANIM_PERIOD, 8: number of frame_start pulses between walk-frame toggles (range 1–255).
- TRANSPARENT_IDX, 3'd0: palette index treated as see-through.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- blank  in  1  1 = active video.
- frame_start  in  1  one-cycle pulse per frame, during vertical blank.
- link_x, link_y  in  10 each  top-left corner of the sprite.
- dir_req  in  2  requested facing: 0 down, 1 up, 2 left, 3 right.
- moving  in  1  1 = Link is walking.
- rom_sel  out  2  selects the direction ROM; same encoding as dir_req.
- rom_address  out  11  {anim_frame, row[4:0], col[4:0]}. Each ROM holds 2 frames × 1024 entries.
- rom_q  in  3  palette index from the selected ROM; registered read, 1-cycle latency.
- pixel_index  out  3  palette index for the colour mapper.
- sprite_on  out  1  1 = draw pixel_index; 0 = background shows through.

## Operation
- Frame latch: on a cycle with frame_start = 1, capture the following, then hold them for the whole frame:
  - link_x into pos_x and link_y into pos_y.
  - dir_req into rom_sel.
  - moving into mov.
- No mid-frame tearing: a position or direction change between frame_start pulses is not visible.
- State machine: STAND, WALK_A, WALK_B. It advances only on frame_start cycles.
  - STAND: anim_frame = 0 and anim_cnt = 0. Moves to WALK_A when moving = 1.
  - WALK_A: anim_frame = 0. WALK_B: anim_frame = 1.
  - In WALK_A/WALK_B, anim_cnt increments on each frame_start. On reaching ANIM_PERIOD−1 it clears to 0 and the state toggles between A and B.
  - Any WALK state goes to STAND when moving = 0.
  - A direction change (dir_req ≠ rom_sel) while moving = 1 forces WALK_A and clears anim_cnt.
- In-box test: dx = DrawX − pos_x and dy = DrawY − pos_y, computed in 11-bit two's complement.
  - in_box = 1 when 0 ≤ dx ≤ 31 and 0 ≤ dy ≤ 31.
  - No wrap-around: a sprite with pos_x = 630 covers DrawX 630–639 only.
- Address: rom_address = {anim_frame, dy[4:0], dx[4:0]}. When in_box = 0, rom_address = 0.
- Output: sprite_on = in_box ∧ blank ∧ (rom_q ≠ TRANSPARENT_IDX), using in_box and blank delayed to align with rom_q. pixel_index = rom_q when sprite_on = 1, else 0.

## Timing
- Reset (reset_n = 0, asynchronous, takes effect at any point including mid-line):
  - Outputs: rom_sel = 0, rom_address = 0, pixel_index = 0, sprite_on = 0.
  - Internal: state = STAND, anim_cnt = 0, pos_x = pos_y = 0, mov = 0, all pipeline valid bits 0.
- Pipeline, for DrawX/DrawY/blank sampled at edge k:
  - rom_address is registered at edge k.
  - The ROM registers rom_q at edge k+1.
  - pixel_index and sprite_on are registered at edge k+2.
  - Total latency: 3 edges. in_box and blank are carried through 2 delay stages to match.
- Frame latch: on the frame_start edge, the new pos/rom_sel/state take effect for addresses generated on the following cycle.
- rom_sel changes only on frame_start edges. The pipeline is not flushed. frame_start must occur in vertical blank, when blank = 0 and sprite_on is 0 regardless.
- frame_start on two consecutive cycles: each pulse counts as one frame (anim_cnt += 2). The source guarantees single-cycle pulses, so this is legal but not expected.
- ANIM_PERIOD = 1: toggle on every frame_start.

## Test plan
- Reset mid-frame: drive reset_n low while sprite_on = 1 → sprite_on, pixel_index and rom_address are 0 within the same cycle. After release, the state is STAND and rom_sel = 0.
- Addressing and latency:
  - Setup: link = (100, 50), pulse frame_start, DrawX = 105, DrawY = 53, rom_q model returns index 5.
  - Required: rom_address = 11'h065 after 1 edge. sprite_on = 1 and pixel_index = 5 on the 3rd edge.
- Transparency and edges:
  - rom_q = 0 inside the box → sprite_on = 0.
  - DrawX = 99 or 132 with link_x = 100 → rom_address = 0 and sprite_on = 0.
  - link_x = 630, DrawX = 2 → sprite_on = 0.
- Animation: moving = 1, dir_req = 3, ANIM_PERIOD = 8.
  - rom_sel = 3 after the first frame_start.
  - anim_frame: 0 for frames 1–8, 1 for frames 9–16, then 0 again.
  - moving = 0 → anim_frame = 0 at the next frame_start.
- Mid-frame changes:
  - Changing dir_req from 3 to 2 in mid-frame → rom_sel stays 3 until frame_start, then becomes 2 with anim_frame = 0.
  - Changing link_x mid-frame → the in-box test keeps using the old pos_x until frame_start.

Source files
------------

// File: rtl/link_sprite_ctrl.sv
// rtl/link_sprite_ctrl.sv - Link sprite ROM sequencer: frame latch, walk animation, pixel pipeline
module link_sprite_ctrl #(
  parameter int unsigned ANIM_PERIOD     = 8,
  parameter logic [2:0]  TRANSPARENT_IDX = 3'd0
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        frame_start,
  input  logic [9:0]  link_x,
  input  logic [9:0]  link_y,
  input  logic [1:0]  dir_req,
  input  logic        moving,
  output logic [1:0]  rom_sel,
  output logic [10:0] rom_address,
  input  logic [2:0]  rom_q,
  output logic [2:0]  pixel_index,
  output logic        sprite_on
);

  typedef enum logic [1:0] {STAND, WALK_A, WALK_B} state_t;

  localparam logic [7:0] CNT_LAST = 8'(ANIM_PERIOD - 1);

  state_t      state;
  logic [7:0]  anim_cnt;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        mov;
  logic        anim_frame;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_box;
  logic        in_box_d1;
  logic        in_box_d2;
  logic        blank_d1;
  logic        blank_d2;
  logic        draw_now;

  assign anim_frame = mov && (state == WALK_B);

  // Zero-extended 11-bit differences: a negative offset sets the upper bits, so one
  // range test rejects both sides and the sprite never wraps around the screen edge.
  assign dx     = {1'b0, DrawX} - {1'b0, pos_x};
  assign dy     = {1'b0, DrawY} - {1'b0, pos_y};
  assign in_box = (dx[10:5] == 6'd0) && (dy[10:5] == 6'd0);

  assign draw_now = in_box_d2 && blank_d2 && (rom_q != TRANSPARENT_IDX);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= STAND;
      anim_cnt <= 8'd0;
      pos_x    <= 10'd0;
      pos_y    <= 10'd0;
      rom_sel  <= 2'd0;
      mov      <= 1'b0;
    end else if (frame_start) begin
      pos_x   <= link_x;
      pos_y   <= link_y;
      rom_sel <= dir_req;
      mov     <= moving;
      if (!moving) begin
        state    <= STAND;
        anim_cnt <= 8'd0;
      end else if (state == STAND || dir_req != rom_sel) begin
        state    <= WALK_A;
        anim_cnt <= 8'd0;
      end else if (anim_cnt == CNT_LAST) begin
        anim_cnt <= 8'd0;
        state    <= (state == WALK_A) ? WALK_B : WALK_A;
      end else begin
        anim_cnt <= anim_cnt + 8'd1;
      end
    end
  end

  // Three-edge pixel path: address, external ROM read, then opacity decision.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= 11'd0;
      in_box_d1   <= 1'b0;
      in_box_d2   <= 1'b0;
      blank_d1    <= 1'b0;
      blank_d2    <= 1'b0;
      sprite_on   <= 1'b0;
      pixel_index <= 3'd0;
    end else begin
      rom_address <= in_box ? {anim_frame, dy[4:0], dx[4:0]} : 11'd0;
      in_box_d1   <= in_box;
      blank_d1    <= blank;
      in_box_d2   <= in_box_d1;
      blank_d2    <= blank_d1;
      sprite_on   <= draw_now;
      pixel_index <= draw_now ? rom_q : 3'd0;
    end
  end

endmodule

// File: tb/tb_link_sprite_ctrl.sv
// tb/tb_link_sprite_ctrl.sv - randomized self-checking bench for link_sprite_ctrl
module tb_link_sprite_ctrl;

  localparam int PERIOD = 8;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, link_x, link_y;
  logic        blank, frame_start, moving;
  logic [1:0]  dir_req, rom_sel;
  logic [10:0] rom_address;
  logic [2:0]  rom_q, pixel_index;
  logic        sprite_on;

  logic [2:0] rom [0:3][0:2047];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: frame-level view of the sprite plus expected pixel outputs
  logic [9:0]  m_px, m_py;
  logic [1:0]  m_sel;
  bit          m_walking;
  int          m_wcnt;
  logic [10:0] e_addr;
  logic [2:0]  e_q, e_idx;
  bit          e_on, vis1, vis2;

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= rom[rom_sel][rom_address];

  link_sprite_ctrl #(.ANIM_PERIOD(PERIOD), .TRANSPARENT_IDX(3'd0)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .link_x(link_x), .link_y(link_y),
    .dir_req(dir_req), .moving(moving), .rom_sel(rom_sel), .rom_address(rom_address),
    .rom_q(rom_q), .pixel_index(pixel_index), .sprite_on(sprite_on)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_anim();
    return m_walking && (((m_wcnt / PERIOD) % 2) == 1);
  endfunction

  task automatic model_reset();
    m_px = 0; m_py = 0; m_sel = 0; m_walking = 0; m_wcnt = 0;
    e_addr = 0; e_q = rom[0][0]; e_idx = 0; e_on = 0; vis1 = 0; vis2 = 0;
  endtask

  task automatic model_frame();
    if (!moving) m_walking = 0;
    else if (!m_walking || dir_req != m_sel) begin
      m_walking = 1;
      m_wcnt = 0;
    end else m_wcnt++;
    m_px = link_x; m_py = link_y; m_sel = dir_req;
  endtask

  task automatic tick();
    int dxi, dyi;
    bit inb;
    logic [10:0] a;
    @(posedge vga_clk);
    dxi = int'(DrawX) - int'(m_px);
    dyi = int'(DrawY) - int'(m_py);
    inb = dxi >= 0 && dxi < 32 && dyi >= 0 && dyi < 32;
    a = inb ? {model_anim(), 5'(dyi), 5'(dxi)} : 11'd0;
    e_on  = vis2 && (e_q != 3'd0);
    e_idx = e_on ? e_q : 3'd0;
    e_q   = rom[m_sel][e_addr];
    e_addr = a;
    vis2 = vis1;
    vis1 = inb && blank;
    if (frame_start) model_frame();
    #1;
    check("rom_address", rom_address, e_addr);
    check("rom_sel", rom_sel, m_sel);
    check("sprite_on", sprite_on, e_on);
    check("pixel_index", pixel_index, e_idx);
  endtask

  task automatic do_reset();
    reset_n = 0; frame_start = 0; blank = 0;
    repeat (2) @(posedge vga_clk);
    #1;
    check("rst_addr", rom_address, 0);
    check("rst_sel", rom_sel, 0);
    check("rst_on", sprite_on, 0);
    check("rst_idx", pixel_index, 0);
    reset_n = 1;
    model_reset();
  endtask

  task automatic pulse(input logic [9:0] lx, input logic [9:0] ly, input logic [1:0] d, input logic mv);
    link_x = lx; link_y = ly; dir_req = d; moving = mv;
    frame_start = 1; blank = 0;
    tick();
    frame_start = 0; blank = 1;
  endtask

  initial begin
    int v;
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 2048; i++) rom[d][i] = 3'($urandom_range(0, 7));
    DrawX = 0; DrawY = 0; link_x = 0; link_y = 0; dir_req = 0; moving = 0;
    do_reset();

    // addressing and latency
    rom[0][11'h065] = 3'd5;
    pulse(10'd100, 10'd50, 2'd0, 1'b0);
    DrawX = 10'd105; DrawY = 10'd53;
    tick();
    check("addr_065", rom_address, 11'h065);
    tick();
    tick();
    check("lat_on", sprite_on, 1);
    check("lat_idx", pixel_index, 5);

    // asynchronous reset between edges while drawing
    #2 reset_n = 0;
    #1;
    check("amid_on", sprite_on, 0);
    check("amid_idx", pixel_index, 0);
    check("amid_addr", rom_address, 0);
    #1 reset_n = 1;
    model_reset();
    tick();
    check("post_rst_sel", rom_sel, 0);

    // transparency and box edges
    pulse(10'd100, 10'd50, 2'd0, 1'b0);
    rom[0][{1'b0, 5'd3, 5'd10}] = 3'd0;
    DrawX = 10'd110; tick(); tick(); tick();
    check("transparent", sprite_on, 0);
    DrawX = 10'd99; tick();
    check("left_edge_addr", rom_address, 0);
    DrawX = 10'd132; tick();
    check("right_edge_addr", rom_address, 0);
    tick(); tick();
    check("right_edge_on", sprite_on, 0);
    pulse(10'd630, 10'd50, 2'd0, 1'b0);
    DrawX = 10'd2; tick(); tick(); tick();
    check("no_wrap", sprite_on, 0);
    DrawX = 10'd639; repeat (3) tick();

    // walk animation
    do_reset();
    DrawX = 10'd210; DrawY = 10'd110;
    for (int n = 1; n <= 20; n++) begin
      pulse(10'd200, 10'd100, 2'd3, 1'b1);
      tick();
      if (n == 1) check("sel_after_first", rom_sel, 3);
      check("anim_frame", rom_address[10], ((n - 1) / 8) % 2);
    end
    pulse(10'd200, 10'd100, 2'd3, 1'b0);
    tick();
    check("stop_anim", rom_address[10], 0);

    // mid-frame direction and position changes
    for (int n = 1; n <= 9; n++) pulse(10'd200, 10'd100, 2'd3, 1'b1);
    tick();
    check("walk_b", rom_address[10], 1);
    dir_req = 2'd2; tick();
    check("sel_hold", rom_sel, 3);
    pulse(10'd200, 10'd100, 2'd2, 1'b1);
    tick();
    check("sel_new", rom_sel, 2);
    check("dir_restart", rom_address[10], 0);
    link_x = 10'd300; DrawX = 10'd205; tick();
    check("old_pos_x", rom_address[9:0], 10'h145);
    pulse(10'd300, 10'd100, 2'd2, 1'b1);
    tick();
    check("new_pos_out", rom_address, 0);
    DrawX = 10'd305; tick();
    check("new_pos_in", rom_address[9:0], 10'h145);

    // randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        link_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(600, 639)) : 10'($urandom_range(0, 639));
        link_y = 10'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 99) == 0) dir_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) moving = ~moving;
      if ($urandom_range(0, 39) == 0) begin
        frame_start = 1; blank = 0;
      end else begin
        frame_start = 0; blank = ($urandom_range(0, 3) != 0);
      end
      v = int'(m_px) + int'($urandom_range(0, 40)) - 4;
      if (v < 0) v = 0;
      if (v > 639) v = 639;
      DrawX = 10'(v);
      v = int'(m_py) + int'($urandom_range(0, 40)) - 4;
      if (v < 0) v = 0;
      if (v > 479) v = 479;
      DrawY = 10'(v);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
